// File: rtl/seg7_pkg.sv
// Shared 7-segment tables and reader FSM states (active-high, bit0=a .. bit6=g).
// Also used by the forward digit-to-segment decoder so both ends share one table.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational segment-pattern to digit lookup.
// Define SEG7_READER_HEX_EN to accept the A..F glyphs as digits 10..15.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    digit = '0;
    legal = 1'b1;
    blank = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
`ifdef SEG7_READER_HEX_EN
      SEG_HEX_A: digit = 4'd10;
      SEG_HEX_B: digit = 4'd11;
      SEG_HEX_C: digit = 4'd12;
      SEG_HEX_D: digit = 4'd13;
      SEG_HEX_E: digit = 4'd14;
      SEG_HEX_F: digit = 4'd15;
`endif
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_reader.sv
// Recovers the displayed digit from a 7-segment bus with stability filtering.
// Optional macro SEG7_READER_HEX_EN (handled in seg7_pattern_lookup) adds A..F.
module seg7_pattern_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] codein,
  input  logic       seg_en,
  output logic [3:0] q,
  output logic       q_valid,
  output logic       q_err,
  output logic       q_lock
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]    sample_r, prev_r;
  logic          en_r;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, count_v;
  logic [3:0]    q_nx, lk_digit;
  logic          valid_nx, err_nx, lock_nx;
  logic          lk_legal, lk_blank, changed, attempt;

  seg7_pattern_lookup u_lookup (
    .pattern (sample_r),
    .digit   (lk_digit),
    .legal   (lk_legal),
    .blank   (lk_blank)
  );

  // The count is resolved combinationally so STABLE_CYCLES=1 accepts on the
  // first registered sample, both from IDLE and on a change seen in HOLD.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = q;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    lock_nx  = q_lock;
    attempt  = 1'b0;
    count_v  = '0;
    changed  = (sample_r != prev_r);
    if (!en_r) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      lock_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          attempt = 1'b1;
          count_v = CNT_ONE;
        end
        SETTLE: begin
          attempt = 1'b1;
          if (changed)             count_v = CNT_ONE;
          else if (cnt >= CNT_MAX) count_v = cnt;
          else                     count_v = cnt + CNT_ONE;
        end
        HOLD: begin
          if (changed) begin
            attempt = 1'b1;
            count_v = CNT_ONE;
            lock_nx = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          lock_nx  = 1'b0;
        end
      endcase
      if (attempt) begin
        cnt_nx = count_v;
        if (count_v >= CNT_MAX) begin
          state_nx = HOLD;
          if (lk_legal) begin
            q_nx     = lk_digit;
            valid_nx = 1'b1;
            lock_nx  = 1'b1;
          end else begin
            err_nx  = !lk_blank;
            lock_nx = 1'b0;
          end
        end else begin
          state_nx = SETTLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r <= '0;
      prev_r   <= '0;
      en_r     <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      q_err    <= 1'b0;
      q_lock   <= 1'b0;
    end else begin
      sample_r <= codein;
      prev_r   <= sample_r;
      en_r     <= seg_en;
      state    <= state_nx;
      cnt      <= cnt_nx;
      q        <= q_nx;
      q_valid  <= valid_nx;
      q_err    <= err_nx;
      q_lock   <= lock_nx;
    end
  end

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Scoreboard bench for seg7_pattern_reader: expected strobes are queued with
// their due edge when a pattern is driven and matched as the DUT strobes.
module tb_seg7_pattern_reader;

  localparam int unsigned S = 4;
  localparam logic [1:0] K_NONE  = 2'b00;
  localparam logic [1:0] K_VALID = 2'b10;
  localparam logic [1:0] K_ERR   = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] codein = '0;
  logic       seg_en = 1'b0;
  logic [3:0] q;
  logic       q_valid, q_err, q_lock;

  typedef struct {
    int         due;
    logic [1:0] kind;
    logic [3:0] qv;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg7_pattern_reader #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .codein  (codein),
    .seg_en  (seg_en),
    .q       (q),
    .q_valid (q_valid),
    .q_err   (q_err),
    .q_lock  (q_lock)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Hold a pattern for n cycles; a strobe of the given kind is due S+1 edges
  // after the pattern is first presented.
  task automatic present(input logic [6:0] code, input logic en, input int n,
                         input logic [1:0] kind, input logic [3:0] qexp);
    exp_t e;
    @(negedge clk);
    codein = code;
    seg_en = en;
    if (kind != K_NONE) begin
      e.due  = cyc + 1 + int'(S);
      e.kind = kind;
      e.qv   = qexp;
      sb.push_back(e);
    end
    repeat (n - 1) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q_valid || q_err) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, q_valid, q_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_edge", cyc, e.due);
        check("strobe_kind", {30'd0, q_valid, q_err}, {30'd0, e.kind});
        check("strobe_q", {28'd0, q}, {28'd0, e.qv});
        check("strobe_lock", {31'd0, q_lock}, {31'd0, e.kind == K_VALID});
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      exp_t e;
      e = sb.pop_front();
      check("missed_strobe", cyc, e.due);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_valid", {31'd0, q_valid}, 32'd0);
    check("rst_err", {31'd0, q_err}, 32'd0);
    check("rst_lock", {31'd0, q_lock}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    present(7'h5B, 1'b1, 10, K_VALID, 4'd2);
    check("lock_after_2", {31'd0, q_lock}, 32'd1);

    present(7'h06, 1'b1, 2, K_NONE, 4'd0);
    present(7'h4F, 1'b1, 8, K_VALID, 4'd3);

    present(7'h12, 1'b1, 8, K_ERR, 4'd3);
    check("lock_after_illegal", {31'd0, q_lock}, 32'd0);
    present(7'h00, 1'b1, 8, K_NONE, 4'd0);
    check("blank_lock", {31'd0, q_lock}, 32'd0);
    check("blank_q_kept", {28'd0, q}, 32'd3);

    present(7'h7F, 1'b1, 8, K_VALID, 4'd8);
    present(7'h6F, 1'b1, 8, K_VALID, 4'd9);
    present(7'h7F, 1'b1, 8, K_VALID, 4'd8);
    present(7'h7F, 1'b0, 3, K_NONE, 4'd0);
    check("en_low_lock", {31'd0, q_lock}, 32'd0);
    present(7'h7F, 1'b1, 8, K_VALID, 4'd8);

    present(7'h66, 1'b1, 2, K_NONE, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_q", {28'd0, q}, 32'd0);
    check("midrst_valid", {31'd0, q_valid}, 32'd0);
    check("midrst_err", {31'd0, q_err}, 32'd0);
    check("midrst_lock", {31'd0, q_lock}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      e.due  = cyc + 1 + int'(S);
      e.kind = K_VALID;
      e.qv   = 4'd4;
      sb.push_back(e);
    end
    repeat (8) @(negedge clk);

`ifdef SEG7_READER_HEX_EN
    present(7'h77, 1'b1, 8, K_VALID, 4'd10);
`else
    present(7'h77, 1'b1, 8, K_ERR, 4'd4);
`endif

    present(7'h00, 1'b1, 8, K_NONE, 4'd0);
    present(7'h00, 1'b0, 4, K_NONE, 4'd0);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
